// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready request into one APB transfer to GPIO or UART.
// It returns a one-cycle response, including for decode errors and wait-state timeouts.
module apb_master_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic [2:0]        PPROT,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DERR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [2:0]         pprot_q, pprot_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // select field 1x is unmapped: answer with an error, leave the bus untouched
          if (req_addr[SEL_LSB+1]) begin
            state_d = S_DERR;
          end else begin
            state_d   = S_SETUP;
            psel_d    = req_addr[SEL_LSB] ? 2'b10 : 2'b01;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = req_addr;
            pwdata_d  = req_wdata;
            pprot_d   = req_prot;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a transaction-level model predicts every output each cycle,
// and directed transfers pin latency and response values with literal expectations.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // transaction-level model: one transfer, k = edges since its accept
  bit          busy, accepted_now, want_req;
  int          k, end_k;
  bit          t_write, t_derr, t_slv;
  logic [31:0] t_addr, t_prdata;
  int          t_w;
  bit          nxt_write, nxt_slv;
  logic [31:0] nxt_addr, nxt_wdata, nxt_prdata;
  logic [2:0]  nxt_prot;
  int          nxt_w;

  logic        e_ready, e_rsp_valid, e_err, e_penable, e_pwrite;
  logic [1:0]  e_psel;
  logic [31:0] e_rdata, e_paddr, e_pwdata;
  logic [2:0]  e_pprot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; accepted_now = 0; want_req = 0; k = 0; end_k = 0;
    e_ready = 1; e_rsp_valid = 0; e_err = 0; e_penable = 0; e_pwrite = 0;
    e_psel = 0; e_rdata = 0; e_paddr = 0; e_pwdata = 0; e_pprot = 0;
  endtask

  // called right at a rising edge, before inputs change
  task automatic model_edge();
    bit tmo;
    accepted_now = 0;
    if (busy && k < end_k) begin
      k++;
    end else begin
      busy = 0;
      if (req_valid) begin
        busy = 1; k = 0; accepted_now = 1; want_req = 0;
        t_write = req_write; t_addr = req_addr; t_derr = req_addr[13];
        t_w = nxt_w; t_slv = nxt_slv; t_prdata = nxt_prdata;
        end_k = t_derr ? 1 : ((t_w > 15 ? 15 : t_w) + 2);
        if (!t_derr) begin
          e_paddr = req_addr; e_pwdata = req_wdata; e_pwrite = req_write; e_pprot = req_prot;
        end
      end
    end
    e_ready = 1; e_rsp_valid = 0; e_psel = 0; e_penable = 0;
    if (busy) begin
      tmo = (t_w >= 16);
      if (k == end_k) begin
        e_rsp_valid = 1;
        e_err = t_derr || tmo || t_slv;
        e_rdata = (t_derr || tmo || t_write) ? 32'h0 : t_prdata;
      end else begin
        e_ready = 0;
        if (!t_derr) begin
          e_psel = t_addr[12] ? 2'b10 : 2'b01;
          e_penable = (k >= 1);
        end
      end
    end
  endtask

  task automatic drive();
    if (e_ready) begin
      req_valid = want_req; req_write = nxt_write; req_addr = nxt_addr;
      req_wdata = nxt_wdata; req_prot = nxt_prot;
    end else begin
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_prot = 3'($urandom);
    end
    if (busy && !t_derr && k >= 1 && k < end_k) begin
      if (k - 1 == t_w) begin
        PREADY = 1; PSLVERR = t_slv; PRDATA = t_prdata;
      end else begin
        PREADY = 0; PSLVERR = 1; PRDATA = $urandom;
      end
    end else begin
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    model_edge();
    #2;
    drive();
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] prot, input int w, input bit slv,
                         input logic [31:0] prdata, output int lat, output int en_cyc,
                         output int sel_cyc);
    bit started, done;
    int n;
    nxt_write = wr; nxt_addr = addr; nxt_wdata = wdata; nxt_prot = prot;
    nxt_w = w; nxt_slv = slv; nxt_prdata = prdata;
    want_req = 1;
    drive();
    lat = -1; en_cyc = 0; sel_cyc = 0; started = 0; done = 0; n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (accepted_now) begin started = 1; n = 0; end
      else if (started) n++;
      if (started && PSEL != 2'b00) sel_cyc++;
      if (started && PENABLE) en_cyc++;
      if (started && rsp_valid && lat < 0) lat = n;
      if (busy && k == end_k) begin done = 1; break; end
    end
    chk("txn_completes_in_budget", 32'(done), 32'd1);
  endtask

  always @(negedge PCLK) begin
    if (PRESETn && chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("PSEL", 32'(PSEL), 32'(e_psel));
      chk("PENABLE", 32'(PENABLE), 32'(e_penable));
      chk("PADDR", PADDR, e_paddr);
      chk("PWDATA", PWDATA, e_pwdata);
      chk("PWRITE", 32'(PWRITE), 32'(e_pwrite));
      chk("PPROT", 32'(PPROT), 32'(e_pprot));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_PSEL"}, 32'(PSEL), 32'd0);
    chk({tag, "_PENABLE"}, 32'(PENABLE), 32'd0);
    chk({tag, "_PWRITE"}, 32'(PWRITE), 32'd0);
    chk({tag, "_PADDR"}, PADDR, 32'd0);
    chk({tag, "_PWDATA"}, PWDATA, 32'd0);
    chk({tag, "_PPROT"}, 32'(PPROT), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en, sel, gap;
    logic [31:0] a;
    model_reset();
    nxt_write = 0; nxt_addr = 0; nxt_wdata = 0; nxt_prot = 0;
    nxt_w = 0; nxt_slv = 0; nxt_prdata = 0;
    #12;
    chk_all_zero("reset");
    @(posedge PCLK); #2;
    PRESETn = 1; chk_en = 1;
    drive();

    // latency is counted in edges from the accept edge to the edge raising rsp_valid
    run_txn(1, 32'h0000_0002, 32'h0F, 3'd0, 0, 0, 32'h0, lat, en, sel);
    chk("gpio_wr_lat", 32'(lat), 32'd2);
    chk("gpio_wr_penable_cycles", 32'(en), 32'd1);
    chk("gpio_wr_psel_cycles", 32'(sel), 32'd2);
    chk("gpio_wr_err", 32'(rsp_err), 32'd0);
    chk("gpio_wr_rdata", rsp_rdata, 32'd0);

    run_txn(0, 32'h0000_1000, 32'h0, 3'd5, 3, 0, 32'hA5, lat, en, sel);
    chk("uart_rd_lat", 32'(lat), 32'd5);
    chk("uart_rd_penable_cycles", 32'(en), 32'd4);
    chk("uart_rd_rdata", rsp_rdata, 32'hA5);

    run_txn(1, 32'h0000_2000, 32'h1234, 3'd1, 0, 0, 32'h0, lat, en, sel);
    chk("derr_lat", 32'(lat), 32'd1);
    chk("derr_psel_cycles", 32'(sel), 32'd0);
    chk("derr_penable_cycles", 32'(en), 32'd0);
    chk("derr_err", 32'(rsp_err), 32'd1);

    run_txn(0, 32'h0000_0040, 32'h0, 3'd2, 99, 0, 32'hFF, lat, en, sel);
    chk("timeout_lat", 32'(lat), 32'd17);
    chk("timeout_penable_cycles", 32'(en), 32'd16);
    chk("timeout_err", 32'(rsp_err), 32'd1);
    chk("timeout_rdata", rsp_rdata, 32'd0);

    run_txn(0, 32'h0000_0010, 32'h0, 3'd0, 15, 0, 32'h77, lat, en, sel);
    chk("last_wait_lat", 32'(lat), 32'd17);
    chk("last_wait_err", 32'(rsp_err), 32'd0);
    chk("last_wait_rdata", rsp_rdata, 32'h77);

    run_txn(0, 32'h0000_0004, 32'h0, 3'd0, 0, 1, 32'h33, lat, en, sel);
    chk("slverr_err", 32'(rsp_err), 32'd1);
    chk("slverr_rdata", rsp_rdata, 32'h33);

    run_txn(0, 32'h0000_0008, 32'h0, 3'd0, 2, 0, 32'h5A, lat, en, sel);
    chk("midwait_slverr_ignored_err", 32'(rsp_err), 32'd0);
    chk("midwait_slverr_ignored_rdata", rsp_rdata, 32'h5A);

    // reset while the transfer sits in ACCESS
    nxt_write = 1; nxt_addr = 32'h0000_0020; nxt_wdata = 32'hCAFE; nxt_prot = 3'd7;
    nxt_w = 10; nxt_slv = 0; nxt_prdata = 0;
    want_req = 1;
    drive();
    repeat (4) step();
    #1 PRESETn = 0;
    #1 chk_all_zero("async_reset");
    model_reset();
    req_valid = 0; PREADY = 0;
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1;
    drive();
    run_txn(1, 32'h0000_0002, 32'h0F, 3'd0, 0, 0, 32'h0, lat, en, sel);
    chk("post_reset_lat", 32'(lat), 32'd2);
    chk("post_reset_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < 250; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      a = $urandom;
      a[13:12] = 2'($urandom_range(0, 3));
      run_txn(1'($urandom), a, $urandom, 3'($urandom),
              ($urandom_range(0, 5) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3),
              1'($urandom), $urandom, lat, en, sel);
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
